// File: rtl/fir_cap_pkg.sv
// Shared constants for the FIR output capture block: default widths,
// requantisation shift, saturation limits and the round-half-up constant.
package fir_cap_pkg;

  localparam int SAMPLE_IN_WIDTH_DEF  = 32;
  localparam int SAMPLE_OUT_WIDTH_DEF = 16;
  localparam int FRAC_SHIFT_DEF       = 15;
  localparam int FIFO_DEPTH_DEF       = 8;

  // Limits and rounding constant at the default widths (Q15 coefficients).
  localparam logic [SAMPLE_OUT_WIDTH_DEF-1:0] SAT_MAX     = 16'h7FFF;
  localparam logic [SAMPLE_OUT_WIDTH_DEF-1:0] SAT_MIN     = 16'h8000;
  localparam logic [SAMPLE_IN_WIDTH_DEF-1:0]  ROUND_CONST = 32'h0000_4000;

endpackage

// File: rtl/fir_out_capture_if.sv
// Output stream of the capture block: FWFT head sample with valid/ready.
interface fir_out_capture_if #(
  parameter int WIDTH = fir_cap_pkg::SAMPLE_OUT_WIDTH_DEF
) ();

  logic signed [WIDTH-1:0] sample_out;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output sample_out, output out_valid, input  out_ready);
  modport slave  (input  sample_out, input  out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and wrap-bit pointers;
// a push into a full FIFO succeeds only when a pop frees the head the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_out_capture.sv
// Captures raw FIR samples, rounds/shifts/saturates them to the output width
// and buffers them in a FWFT FIFO, keeping sticky overflow/saturation flags.
module fir_out_capture
  import fir_cap_pkg::*;
#(
  parameter int SAMPLE_IN_WIDTH  = SAMPLE_IN_WIDTH_DEF,
  parameter int SAMPLE_OUT_WIDTH = SAMPLE_OUT_WIDTH_DEF,
  parameter int FRAC_SHIFT       = FRAC_SHIFT_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic                              En_CAP,
  input  logic signed [SAMPLE_IN_WIDTH-1:0] sample_in,
  fir_out_capture_if.master                 out_if,
  output logic                              overflow,
  output logic                              sat_flag,
  output logic [15:0]                       sample_count
);

  localparam int EXT_W = SAMPLE_IN_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] MAX_EXT =
    {{(SAMPLE_IN_WIDTH-SAMPLE_OUT_WIDTH+2){1'b0}}, {(SAMPLE_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_EXT =
    {{(SAMPLE_IN_WIDTH-SAMPLE_OUT_WIDTH+2){1'b1}}, {(SAMPLE_OUT_WIDTH-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] ROUND_EXT = EXT_W'(1) << (FRAC_SHIFT - 1);

  logic signed [SAMPLE_IN_WIDTH-1:0] s1_data;
  logic                              s1_valid;
  logic signed [EXT_W-1:0]           rounded;
  logic signed [EXT_W-1:0]           shifted;
  logic [SAMPLE_OUT_WIDTH-1:0]       sat_data;
  logic                              clipped;
  logic [SAMPLE_OUT_WIDTH-1:0]       head;
  logic [SAMPLE_OUT_WIDTH-1:0]       last_out;
  logic                              full;
  logic                              empty;
  logic                              pop;
  logic                              wr_accept;

  // Stage 1: the valid bit qualifies the data, so only the valid bit is reset.
  always_ff @(posedge CLK) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= En_CAP;
    s1_data <= sample_in;
  end

  // Stage 2: round half up in one extra bit, arithmetic shift, clip.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rounded  = $signed({s1_data[SAMPLE_IN_WIDTH-1], s1_data}) + ROUND_EXT;
    shifted  = rounded >>> FRAC_SHIFT;
    sat_data = shifted[SAMPLE_OUT_WIDTH-1:0];
    clipped  = 1'b0;
    if (shifted > MAX_EXT) begin
      sat_data = MAX_EXT[SAMPLE_OUT_WIDTH-1:0];
      clipped  = 1'b1;
    end else if (shifted < MIN_EXT) begin
      sat_data = MIN_EXT[SAMPLE_OUT_WIDTH-1:0];
      clipped  = 1'b1;
    end
  end

  assign pop       = !empty && out_if.out_ready;
  assign wr_accept = s1_valid && (!full || pop);

  sync_fifo #(
    .WIDTH (SAMPLE_OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .rst   (rst),
    .push  (s1_valid),
    .pop   (pop),
    .din   (sat_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // NOTE: registered state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      overflow     <= 1'b0;
      sat_flag     <= 1'b0;
      sample_count <= '0;
      last_out     <= '0;
    end else begin
      if (s1_valid && full && !pop) overflow <= 1'b1;
      if (wr_accept && clipped)     sat_flag <= 1'b1;
      if (wr_accept)                sample_count <= sample_count + 16'd1;
      if (pop)                      last_out <= head;
    end
  end

  // The popped head is remembered so an empty FIFO keeps presenting it.
  assign out_if.out_valid  = !empty;
  assign out_if.sample_out = empty ? last_out : head;

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed bench for fir_out_capture: rounding, saturation, overflow,
// full-with-pop, mid-stream reset and sample counter wrap.
module tb_fir_out_capture;
  import fir_cap_pkg::*;

  logic               CLK = 1'b0;
  logic               rst;
  logic               En_CAP;
  logic signed [31:0] sample_in;
  logic               overflow;
  logic               sat_flag;
  logic [15:0]        sample_count;
  logic [15:0]        so;

  int n_tests = 0;
  int n_fail  = 0;

  fir_out_capture_if #(.WIDTH(16)) cap_if ();
  assign so = cap_if.sample_out;

  fir_out_capture dut (
    .CLK          (CLK),
    .rst          (rst),
    .En_CAP       (En_CAP),
    .sample_in    (sample_in),
    .out_if       (cap_if),
    .overflow     (overflow),
    .sat_flag     (sat_flag),
    .sample_count (sample_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] s);
    En_CAP    = en;
    sample_in = s;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0);
    step();
    rst = 1'b0;
  endtask

  // One sample through an otherwise idle pipe with out_ready=1.
  task automatic single_case(input string tag, input logic [31:0] din,
                             input logic [15:0] exp, input logic exp_sat);
    drive(1'b1, din);
    step();
    drive(1'b0, 32'h0);
    step();
    check({tag, "_valid"}, cap_if.out_valid, 1);
    check({tag, "_out"}, so, exp);
    check({tag, "_sat"}, sat_flag, exp_sat);
    step();
    check({tag, "_empty"}, cap_if.out_valid, 0);
    check({tag, "_hold"}, so, exp);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0);
    cap_if.out_ready = 1'b0;
    step();
    step();
    check("rst_valid", cap_if.out_valid, 0);
    check("rst_out", so, 0);
    check("rst_ovf", overflow, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_cnt", sample_count, 0);
    rst = 1'b0;

    // Rounding and saturation, one sample at a time.
    cap_if.out_ready = 1'b1;
    single_case("rnd_half", 32'h0000_4000, 16'h0001, 1'b0);
    single_case("rnd_below", 32'h0000_3FFF, 16'h0000, 1'b0);
    single_case("rnd_neg", 32'hFFFF_8000, 16'hFFFF, 1'b0);
    single_case("sat_pos", 32'h7FFF_FFFF, SAT_MAX, 1'b1);
    single_case("sat_neg", 32'h8000_0000, SAT_MIN, 1'b1);
    check("sat_cnt", sample_count, 5);

    // Overflow: ten samples into an eight-deep FIFO with no drain.
    pulse_reset();
    cap_if.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i) << 15);
      step();
    end
    drive(1'b0, 32'h0);
    step();
    step();
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", sample_count, 8);
    cap_if.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain_valid", cap_if.out_valid, 1);
      check("ovf_drain_out", so, 32'(i));
      step();
    end
    check("ovf_empty", cap_if.out_valid, 0);
    check("ovf_hold", so, 8);
    step();
    step();
    check("ovf_idle_valid", cap_if.out_valid, 0);
    check("ovf_idle_cnt", sample_count, 8);
    check("ovf_sticky", overflow, 1);

    // Mid-stream reset with buffered and in-flight samples.
    cap_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 2) ? 32'h7FFF_FFFF : (32'(i + 1) << 15));
      step();
    end
    drive(1'b0, 32'h0);
    step();
    step();
    check("mid_sat", sat_flag, 1);
    check("mid_cnt", sample_count, 13);
    drive(1'b1, 32'(7) << 15);
    step();
    rst = 1'b1;
    drive(1'b1, 32'(9) << 15);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    check("mid_valid", cap_if.out_valid, 0);
    check("mid_cnt0", sample_count, 0);
    check("mid_ovf", overflow, 0);
    check("mid_sat0", sat_flag, 0);
    check("mid_out", so, 0);
    step();
    step();
    check("mid_no_inflight", cap_if.out_valid, 0);
    drive(1'b1, 32'h0001_0000);
    step();
    drive(1'b0, 32'h0);
    step();
    check("mid_next_valid", cap_if.out_valid, 1);
    check("mid_next_out", so, 2);

    // Full FIFO with a pop and a write every cycle.
    pulse_reset();
    for (int cyc = 1; cyc <= 25; cyc++) begin
      drive(cyc <= 16, 32'(cyc) << 15);
      cap_if.out_ready = (cyc >= 10);
      if (cyc >= 10) begin
        check("fullpop_valid", cap_if.out_valid, 1);
        check("fullpop_out", so, 32'(cyc - 9));
      end
      step();
    end
    check("fullpop_empty", cap_if.out_valid, 0);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_cnt", sample_count, 16);

    // Counter wrap: 65537 accepted samples.
    pulse_reset();
    cap_if.out_ready = 1'b1;
    drive(1'b1, 32'h0);
    for (int i = 0; i < 65537; i++) step();
    drive(1'b0, 32'h0);
    step();
    step();
    step();
    check("wrap_cnt", sample_count, 1);
    check("wrap_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_capture.md
FIR_OUT_CAPTURE -- requirements
Module: fir_out_capture

Interface
REQ-001 Parameter SAMPLE_IN_WIDTH, default 32, width of raw FIR output samples.
REQ-002 Parameter SAMPLE_OUT_WIDTH, default 16, width of the requantised output samples.
REQ-003 Parameter FRAC_SHIFT, default 15, number of fraction bits removed (Q15 coefficients).
REQ-004 Parameter FIFO_DEPTH, default 8, buffer depth; SHALL be a power of two, minimum 2.
REQ-005 CLK  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 En_CAP  input  1  capture enable; high means sample_in holds a valid sample this cycle.
REQ-008 sample_in  input  SAMPLE_IN_WIDTH  signed two's-complement FIR output sample.
REQ-009 sample_out  output  SAMPLE_OUT_WIDTH  signed requantised sample at the FIFO head.
REQ-010 out_valid  output  1  high when sample_out holds a buffered sample.
REQ-011 out_ready  input  1  downstream accept; a pop SHALL occur when out_valid and out_ready are both high.
REQ-012 overflow  output  1  sticky; a sample was dropped because the FIFO was full.
REQ-013 sat_flag  output  1  sticky; at least one sample was saturated.
REQ-014 sample_count  output  16  count of samples written into the FIFO.

Function
REQ-015 Stage 1 SHALL register sample_in and a valid bit equal to En_CAP at every rising edge.
REQ-016 Stage 2 SHALL add 2^(FRAC_SHIFT-1) in SAMPLE_IN_WIDTH+1 bits, arithmetic-shift right by FRAC_SHIFT (round half up), then saturate to the signed SAMPLE_OUT_WIDTH range.
REQ-017 Saturation limits SHALL be 0x7FFF and 0x8000 at the default width; sat_flag SHALL set on the cycle a clipped sample is written.
REQ-018 The stage-2 result SHALL be written into the FIFO at the next rising edge, so a sample presented at edge N is visible with out_valid=1 after edge N+1 when the FIFO was empty.
REQ-019 The FIFO SHALL be first-word-fall-through: sample_out and out_valid SHALL be driven directly from the head entry and the empty status.
REQ-020 While the FIFO is empty, sample_out SHALL hold its last value, or 0 after reset.
REQ-021 A write into a full FIFO with no pop in the same cycle SHALL drop the incoming sample, leave the FIFO contents unchanged, and set overflow.
REQ-022 A write and a pop in the same cycle while full SHALL both succeed; occupancy stays FIFO_DEPTH and overflow does not change.
REQ-023 A write and a pop in the same cycle while neither empty nor full SHALL leave occupancy unchanged.
REQ-024 out_ready while the FIFO is empty SHALL have no effect.
REQ-025 sample_count SHALL increment on each accepted write, wrap from 0xFFFF to 0x0000, and SHALL NOT count dropped samples.
REQ-026 Deasserting En_CAP SHALL stop new captures only; a sample already in stage 1 SHALL complete, and the FIFO SHALL continue draining.
REQ-027 overflow and sat_flag SHALL clear only on reset.
REQ-028 FIFO read and write pointers SHALL carry one extra wrap bit so that full and empty are distinguished.

Reset
REQ-029 While rst is high at a rising edge, the block SHALL clear the stage valid bits, FIFO pointers, sample_out, overflow, sat_flag and sample_count to 0, and SHALL force out_valid to 0.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight and buffered samples, with no write in that cycle.
REQ-031 The first capture after reset SHALL be the first cycle in which rst is low and En_CAP is high.

Structure
REQ-032 Package fir_cap_pkg SHALL hold the default widths, FRAC_SHIFT, the saturation max/min constants and the rounding constant.
REQ-033 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, din, dout).
REQ-034 The rounding/saturation pipeline and the flag/count logic SHALL live in fir_out_capture.

Verification
REQ-035 Rounding: 0x00004000 -> 0x0001; 0x00003FFF -> 0x0000; 0xFFFF8000 -> 0xFFFF; each appears 2 edges after being driven, with sat_flag=0.
REQ-036 Saturation: 0x7FFFFFFF -> 0x7FFF; 0x80000000 -> 0x8000; sat_flag=1 after the first of them is written.
REQ-037 Overflow: out_ready=0, 10 consecutive samples 1..10 (<<15) -> 8 stored, overflow=1, sample_count=8; drain yields 1..8 in order, after which out_valid=0.
REQ-038 Full with simultaneous pop: FIFO full, out_ready=1, En_CAP=1 -> one pop and one write per cycle, overflow stays 0, order preserved.
REQ-039 Reset mid-stream: 5 samples buffered, rst pulsed for 1 cycle -> out_valid=0, sample_count=0, flags=0; next sample 0x00010000 -> 0x0002.
REQ-040 Count wrap: 65537 accepted samples with out_ready=1 -> sample_count=0x0001.
